fifo_op_ctrl: RTL and testbench
===============================

Name: fifo_op_ctrl

Overview:
Sequences the board-level byte FIFO from the three debounced push-button levels (insert, remove, flush). Converts each button press into exactly one single-cycle FIFO command, blocks illegal commands against full/empty, captures the popped byte for the seven-segment display path, and keeps an occupancy count plus sticky error flags. Sits between the debouncers and the FIFO; its display outputs feed the eight-digit display driver.

Parameters:
DW, 8, data width of FIFO entries and switch input
DEPTH, 8, FIFO capacity in entries; occupancy saturates at DEPTH
CNT_W, 4, occupancy width; must hold 0..DEPTH
REP_CYCLES, 50000000, hold time and repeat period for auto-repeat remove (optional feature only)

Ports:
ck  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
insert_lvl  in  1  debounced insert button level
remove_lvl  in  1  debounced remove button level
flush_lvl  in  1  debounced flush button level
sw_data  in  DW  switch value to push
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
fifo_dout  in  DW  FIFO read data, valid the cycle after fifo_rd
fifo_wr  out  1  one-cycle write strobe
fifo_rd  out  1  one-cycle read strobe
fifo_flush  out  1  one-cycle flush strobe
fifo_din  out  DW  write data, stable while fifo_wr high
shown_data  out  DW  last byte popped, held for display
occupancy  out  CNT_W  current entry count
err_overflow  out  1  sticky: insert pressed while full
err_underflow  out  1  sticky: remove pressed while empty

Behaviour:
- Reset (synchronous on ck, active-high): all strobes 0, fifo_din 0, shown_data 0, occupancy 0, both error flags 0, FSM in IDLE, edge-detector history registers 0. A reset mid-operation aborts the operation; no strobe is issued in the reset cycle.
- Edge detection: a rising edge is a cycle where lvl=1 and the previous-cycle lvl=0. Holding a button issues nothing further; the FIFO sees one command per press.
- FSM states: IDLE, WRITE, READ, CAPTURE, FLUSH. New edges are accepted only in IDLE. Edges arriving in any other state are discarded, not queued.
- Simultaneous edges in one IDLE cycle: priority is flush > remove > insert. Lower-priority edges in that cycle are discarded.
- Insert edge, fifo_full=0: go to WRITE. fifo_din <= sw_data, sampled in the edge cycle. In WRITE, fifo_wr=1 for exactly one cycle and occupancy+1 (saturating at DEPTH). Return to IDLE.
- Insert edge, fifo_full=1: err_overflow <= 1. No strobe. Stay in IDLE.
- Remove edge, fifo_empty=0: go to READ. In READ, fifo_rd=1 for one cycle and occupancy-1 (saturating at 0). Then go to CAPTURE: shown_data <= fifo_dout, then return to IDLE.
- Remove edge, fifo_empty=1: err_underflow <= 1. No strobe.
- Flush edge: go to FLUSH. In FLUSH, fifo_flush=1 for one cycle, occupancy <= 0, shown_data <= 0, both error flags cleared. Return to IDLE.
- Latency from edge cycle to strobe: 1 cycle. Latency to shown_data update after remove: 3 cycles.
- At most one of fifo_wr/fifo_rd/fifo_flush is high in any cycle.
- Error flags clear only on flush or reset.

Optional Feature:
- Macro: FIFO_OP_CTRL_AUTOREPEAT_EN.
- Defined: once remove_lvl has been held continuously for REP_CYCLES after its edge, a READ/CAPTURE sequence is issued every REP_CYCLES while the level stays high. The sequence follows the same full/empty rules as a press. Auto-repeat stops silently at empty and does not set err_underflow. The repeat counter resets when remove_lvl goes low.
- Undefined: no repeat counter in the design; one read per press only.

Decomposition:
- Package fifo_op_ctrl_pkg: FSM state enum (IDLE, WRITE, READ, CAPTURE, FLUSH); op-priority encoding constants.
- Sub-module edge_rise: 1-bit registered rising-edge pulse generator with synchronous reset, instantiated three times.

Test Plan:
- Reset, insert with sw_data=0xA5 -> fifo_wr high exactly 1 cycle, fifo_din=0xA5, occupancy=1.
- Insert 0x11, 0x22, then remove with fifo_dout=0x11 the cycle after fifo_rd -> shown_data=0x11 three cycles after the remove edge, occupancy=1.
- Fill to 8 (fifo_full=1), press insert -> no fifo_wr, err_overflow=1, occupancy stays 8. Then flush -> fifo_flush 1 cycle, occupancy=0, err_overflow=0, shown_data=0.
- fifo_empty=1, press remove -> no fifo_rd, err_underflow=1.
- Insert and flush edges in the same cycle -> only fifo_flush is issued. Hold insert high 100 cycles -> only one fifo_wr.
- Assert reset during READ -> next cycle all strobes 0, occupancy=0, FSM in IDLE.

Source files
------------

// File: rtl/fifo_op_ctrl_pkg.sv
// Shared types for fifo_op_ctrl: FSM state encoding and button-command priority.
package fifo_op_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CAPTURE,
    FLUSH
  } state_e;

  // Numeric order doubles as priority: higher value wins when edges coincide.
  typedef enum logic [1:0] {
    OP_NONE   = 2'd0,
    OP_INSERT = 2'd1,
    OP_REMOVE = 2'd2,
    OP_FLUSH  = 2'd3
  } op_e;

  function automatic op_e pick_op(input logic flush, input logic remove, input logic insert);
    if (flush)  return OP_FLUSH;
    if (remove) return OP_REMOVE;
    if (insert) return OP_INSERT;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge pulse from a debounced level: high in the first cycle the level is seen high.
module edge_rise (
  input  logic ck,
  input  logic reset,
  input  logic lvl,
  output logic pulse
);

  logic prev;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge ck) begin
    if (reset) prev <= 1'b0;
    else       prev <= lvl;
  end

  assign pulse = lvl & ~prev;

endmodule

// File: rtl/fifo_op_ctrl.sv
// Button-to-FIFO command sequencer with occupancy tracking and sticky error flags.
// Optional auto-repeat remove is enabled by defining FIFO_OP_CTRL_AUTOREPEAT_EN.
module fifo_op_ctrl
  import fifo_op_ctrl_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
`ifdef FIFO_OP_CTRL_AUTOREPEAT_EN
  , parameter int REP_CYCLES = 50000000
`endif
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             insert_lvl,
  input  logic             remove_lvl,
  input  logic             flush_lvl,
  input  logic [DW-1:0]    sw_data,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  input  logic [DW-1:0]    fifo_dout,
  output logic             fifo_wr,
  output logic             fifo_rd,
  output logic             fifo_flush,
  output logic [DW-1:0]    fifo_din,
  output logic [DW-1:0]    shown_data,
  output logic [CNT_W-1:0] occupancy,
  output logic             err_overflow,
  output logic             err_underflow
);

  logic   insert_edge, remove_edge, flush_edge;
  logic   rep_pulse;
  state_e state_q, state_d;
  op_e    op;
  logic   load_din, set_ovf, set_unf;

  edge_rise u_edge_insert (.ck(ck), .reset(reset), .lvl(insert_lvl), .pulse(insert_edge));
  edge_rise u_edge_remove (.ck(ck), .reset(reset), .lvl(remove_lvl), .pulse(remove_edge));
  edge_rise u_edge_flush  (.ck(ck), .reset(reset), .lvl(flush_lvl),  .pulse(flush_edge));

  assign op = pick_op(flush_edge, remove_edge, insert_edge);

`ifdef FIFO_OP_CTRL_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REP_CYCLES + 1);
  logic [REP_W-1:0] rep_cnt;

  // Counts continuous remove hold time; a pulse every REP_CYCLES requests another read.
  always_ff @(posedge ck) begin
    if (reset || !remove_lvl) begin
      rep_cnt   <= '0;
      rep_pulse <= 1'b0;
    end else if (rep_cnt == REP_W'(REP_CYCLES - 1)) begin
      rep_cnt   <= '0;
      rep_pulse <= 1'b1;
    end else begin
      rep_cnt   <= rep_cnt + 1'b1;
      rep_pulse <= 1'b0;
    end
  end
`else
  assign rep_pulse = 1'b0;
`endif

  always_ff @(posedge ck) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    fifo_wr    = 1'b0;
    fifo_rd    = 1'b0;
    fifo_flush = 1'b0;
    load_din   = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    unique case (state_q)
      IDLE: begin
        case (op)
          OP_FLUSH:  state_d = FLUSH;
          OP_REMOVE: if (fifo_empty) set_unf = 1'b1;
                     else            state_d = READ;
          OP_INSERT: if (fifo_full)  set_ovf = 1'b1;
                     else begin
                       state_d  = WRITE;
                       load_din = 1'b1;
                     end
          // Auto-repeat reads stop silently at empty, without flagging underflow.
          default:   if (rep_pulse && !fifo_empty) state_d = READ;
        endcase
      end
      // Strobes are masked by reset so an aborted operation never reaches the FIFO.
      WRITE: begin
        fifo_wr = ~reset;
        state_d = IDLE;
      end
      READ: begin
        fifo_rd = ~reset;
        state_d = CAPTURE;
      end
      CAPTURE: state_d = IDLE;
      FLUSH: begin
        fifo_flush = ~reset;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      fifo_din      <= '0;
      shown_data    <= '0;
      occupancy     <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (load_din) fifo_din      <= sw_data;
      if (set_ovf)  err_overflow  <= 1'b1;
      if (set_unf)  err_underflow <= 1'b1;
      case (state_q)
        WRITE:   if (occupancy != CNT_W'(DEPTH)) occupancy <= occupancy + 1'b1;
        READ:    if (occupancy != '0)            occupancy <= occupancy - 1'b1;
        CAPTURE: shown_data <= fifo_dout;
        FLUSH: begin
          occupancy     <= '0;
          shown_data    <= '0;
          err_overflow  <= 1'b0;
          err_underflow <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_op_ctrl.sv
// Self-checking bench for fifo_op_ctrl: directed vector table plus multi-cycle corner sequences.
module tb_fifo_op_ctrl;

  logic       ck = 1'b0;
  logic       reset;
  logic       insert_lvl, remove_lvl, flush_lvl;
  logic [7:0] sw_data;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_wr, fifo_rd, fifo_flush;
  logic [7:0] fifo_din, shown_data;
  logic [3:0] occupancy;
  logic       err_overflow, err_underflow;

  int passed = 0;
  int total  = 0;

  fifo_op_ctrl dut (
    .ck(ck), .reset(reset),
    .insert_lvl(insert_lvl), .remove_lvl(remove_lvl), .flush_lvl(flush_lvl),
    .sw_data(sw_data), .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_flush(fifo_flush), .fifo_din(fifo_din),
    .shown_data(shown_data), .occupancy(occupancy),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic       rst, ins, rem, fl, full, empty;
    logic [7:0] sw, dout;
    logic       wr, rd, fls;
    logic [7:0] din, shown;
    logic [3:0] occ;
    logic       ovf, unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, ins, rem, fl, full, empty,
                              input logic [7:0] sw, dout,
                              input logic wr, rd, fls,
                              input logic [7:0] din, shown,
                              input logic [3:0] occ,
                              input logic ovf, unf);
    vec_t v;
    v.rst = rst; v.ins = ins; v.rem = rem; v.fl = fl; v.full = full; v.empty = empty;
    v.sw = sw; v.dout = dout; v.wr = wr; v.rd = rd; v.fls = fls;
    v.din = din; v.shown = shown; v.occ = occ; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic check_all(input string tag, input logic wr, rd, fls,
                           input logic [7:0] din, shown, input logic [3:0] occ,
                           input logic ovf, unf);
    check({tag, ".wr"},    32'(fifo_wr),       32'(wr));
    check({tag, ".rd"},    32'(fifo_rd),       32'(rd));
    check({tag, ".flush"}, 32'(fifo_flush),    32'(fls));
    check({tag, ".din"},   32'(fifo_din),      32'(din));
    check({tag, ".shown"}, 32'(shown_data),    32'(shown));
    check({tag, ".occ"},   32'(occupancy),     32'(occ));
    check({tag, ".ovf"},   32'(err_overflow),  32'(ovf));
    check({tag, ".unf"},   32'(err_underflow), 32'(unf));
  endtask

  task automatic press_insert(input logic [7:0] val);
    sw_data = val; insert_lvl = 1'b1; tick();
    insert_lvl = 1'b0; tick();
  endtask

  initial begin
    int wr_count;

    reset = 1'b1; insert_lvl = 1'b0; remove_lvl = 1'b0; flush_lvl = 1'b0;
    sw_data = 8'h00; fifo_full = 1'b0; fifo_empty = 1'b1; fifo_dout = 8'h00;
    tick(); tick();
    check_all("reset", 0, 0, 0, 8'h00, 8'h00, 4'd0, 0, 0);
    reset = 1'b0;

    //               rst ins rem fl full emp  sw     dout  | wr rd fl  din    shown  occ  ovf unf
    vecs.push_back(mk(0, 1,  0,  0, 0,   1,   8'hA5, 8'h00,  1, 0, 0, 8'hA5, 8'h00, 4'd0, 0, 0));
    vecs.push_back(mk(0, 1,  0,  0, 0,   0,   8'hA5, 8'h00,  0, 0, 0, 8'hA5, 8'h00, 4'd1, 0, 0));
    vecs.push_back(mk(1, 0,  0,  0, 0,   1,   8'h00, 8'h00,  0, 0, 0, 8'h00, 8'h00, 4'd0, 0, 0));
    vecs.push_back(mk(0, 1,  0,  0, 0,   1,   8'h11, 8'h00,  1, 0, 0, 8'h11, 8'h00, 4'd0, 0, 0));
    vecs.push_back(mk(0, 0,  0,  0, 0,   0,   8'h11, 8'h00,  0, 0, 0, 8'h11, 8'h00, 4'd1, 0, 0));
    vecs.push_back(mk(0, 1,  0,  0, 0,   0,   8'h22, 8'h00,  1, 0, 0, 8'h22, 8'h00, 4'd1, 0, 0));
    vecs.push_back(mk(0, 0,  0,  0, 0,   0,   8'h22, 8'h00,  0, 0, 0, 8'h22, 8'h00, 4'd2, 0, 0));
    vecs.push_back(mk(0, 0,  1,  0, 0,   0,   8'h22, 8'h00,  0, 1, 0, 8'h22, 8'h00, 4'd2, 0, 0));
    vecs.push_back(mk(0, 0,  1,  0, 0,   0,   8'h22, 8'h11,  0, 0, 0, 8'h22, 8'h00, 4'd1, 0, 0));
    vecs.push_back(mk(0, 0,  0,  0, 0,   0,   8'h22, 8'h11,  0, 0, 0, 8'h22, 8'h11, 4'd1, 0, 0));

    foreach (vecs[i]) begin
      reset = vecs[i].rst; insert_lvl = vecs[i].ins; remove_lvl = vecs[i].rem;
      flush_lvl = vecs[i].fl; fifo_full = vecs[i].full; fifo_empty = vecs[i].empty;
      sw_data = vecs[i].sw; fifo_dout = vecs[i].dout;
      tick();
      check_all($sformatf("v%0d", i), vecs[i].wr, vecs[i].rd, vecs[i].fls,
                vecs[i].din, vecs[i].shown, vecs[i].occ, vecs[i].ovf, vecs[i].unf);
    end
    reset = 1'b0; remove_lvl = 1'b0;

    // Fill from 1 to 8 entries, then insert against a full FIFO.
    for (int k = 0; k < 7; k++) press_insert(8'(8'h30 + k));
    check("fill.occ", 32'(occupancy), 32'd8);
    fifo_full = 1'b1; insert_lvl = 1'b1; tick();
    check("ovf.wr", 32'(fifo_wr), 32'd0);
    check("ovf.flag", 32'(err_overflow), 32'd1);
    tick();
    check("ovf.wr2", 32'(fifo_wr), 32'd0);
    check("ovf.occ", 32'(occupancy), 32'd8);
    insert_lvl = 1'b0; fifo_full = 1'b0;

    // Flush clears count, display and error flags.
    flush_lvl = 1'b1; tick();
    check("flush.strobe", 32'(fifo_flush), 32'd1);
    tick();
    check_all("flush.after", 0, 0, 0, 8'h36, 8'h00, 4'd0, 0, 0);
    flush_lvl = 1'b0; tick();

    // Remove against an empty FIFO.
    fifo_empty = 1'b1; remove_lvl = 1'b1; tick();
    check("unf.rd", 32'(fifo_rd), 32'd0);
    check("unf.flag", 32'(err_underflow), 32'd1);
    tick();
    check("unf.rd2", 32'(fifo_rd), 32'd0);
    remove_lvl = 1'b0; tick();

    // Insert and flush edges together: flush wins.
    fifo_empty = 1'b0; insert_lvl = 1'b1; flush_lvl = 1'b1; tick();
    check("simul.flush", 32'(fifo_flush), 32'd1);
    check("simul.wr", 32'(fifo_wr), 32'd0);
    tick();
    check_all("simul.after", 0, 0, 0, 8'h36, 8'h00, 4'd0, 0, 0);
    insert_lvl = 1'b0; flush_lvl = 1'b0; tick();

    // Remove and insert edges together: remove wins.
    insert_lvl = 1'b1; remove_lvl = 1'b1; tick();
    check("prio.rd", 32'(fifo_rd), 32'd1);
    check("prio.wr", 32'(fifo_wr), 32'd0);
    tick();
    check("prio.occ", 32'(occupancy), 32'd0);
    insert_lvl = 1'b0; remove_lvl = 1'b0; tick(); tick();

    // Holding insert for 100 cycles yields a single write.
    wr_count = 0;
    sw_data = 8'h5C; insert_lvl = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (fifo_wr) wr_count++;
    end
    check("hold.wr_count", 32'(wr_count), 32'd1);
    check("hold.occ", 32'(occupancy), 32'd1);
    insert_lvl = 1'b0; tick();
    press_insert(8'h77);
    check("pre_rst.occ", 32'(occupancy), 32'd2);

    // Reset while a read is in flight.
    remove_lvl = 1'b1; tick();
    check("rst_rd.rd", 32'(fifo_rd), 32'd1);
    reset = 1'b1; #1;
    check("rst_rd.masked", 32'(fifo_rd), 32'd0);
    tick();
    check_all("rst_rd.after", 0, 0, 0, 8'h00, 8'h00, 4'd0, 0, 0);
    reset = 1'b0; remove_lvl = 1'b0; tick();
    check("rst_rd.idle_rd", 32'(fifo_rd), 32'd0);
    sw_data = 8'h9E; insert_lvl = 1'b1; tick();
    check("rst_rd.idle_wr", 32'(fifo_wr), 32'd1);
    check("rst_rd.idle_din", 32'(fifo_din), 32'h9E);
    insert_lvl = 1'b0; tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
